// File: rtl/bist_pkg.sv
// Shared types and constants for the BIST response analyzer.
package bist_pkg;

   // Analyzer control states
   typedef enum logic [1:0] {
      ST_IDLE    = 2'd0,
      ST_COMPACT = 2'd1,
      ST_CHECK   = 2'd2,
      ST_DONE    = 2'd3
   } state_t;

   // Verdict error codes
   localparam logic [1:0] ERR_NONE  = 2'd0;
   localparam logic [1:0] ERR_SIG   = 2'd1;
   localparam logic [1:0] ERR_CNT   = 2'd2;
   localparam logic [1:0] ERR_PROTO = 2'd3;

   // Default MISR taps (x^8+x^4+x^3+x^2+1) and golden signature
   localparam logic [7:0] DEF_POLY   = 8'h1D;
   localparam logic [7:0] DEF_GOLDEN = 8'h1F;

endpackage

// File: rtl/bist_misr.sv
// Multiple-input signature register: shifts left, folds the MSB back through
// the feedback taps and XORs in one response word per enabled cycle.
module bist_misr #(
   parameter int               WIDTH = 8,
   parameter logic [WIDTH-1:0] POLY  = WIDTH'(8'h1D)
) (
   input  logic             clk,
   input  logic             reset_n,
   input  logic             clear,
   input  logic             en,
   input  logic [WIDTH-1:0] din,
   output logic [WIDTH-1:0] q
);

   logic [WIDTH-1:0] r_sig;
   logic [WIDTH-1:0] w_fb;

   // Feedback term applied only when the bit shifted out is set
   always_comb begin
      w_fb = r_sig[WIDTH-1] ? POLY : '0;
   end

   // Signature register: clear has priority over compaction
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         r_sig <= '0;
      end else if (clear) begin
         r_sig <= '0;
      end else if (en) begin
         r_sig <= {r_sig[WIDTH-2:0], 1'b0} ^ w_fb ^ din;
      end
   end

   assign q = r_sig;

endmodule

// File: rtl/bist_response_analyzer.sv
// BIST response analyzer: compacts CUT responses while running, then checks
// the signature and cycle count and holds a sticky verdict until init/reset.
module bist_response_analyzer
   import bist_pkg::*;
#(
   parameter int               WIDTH  = 8,
   parameter int               NCLOCK = 5,
   parameter logic [WIDTH-1:0] POLY   = WIDTH'(DEF_POLY),
   parameter logic [WIDTH-1:0] GOLDEN = WIDTH'(DEF_GOLDEN)
) (
   input  logic             clk,
   input  logic             reset_n,
   input  logic             init,
   input  logic             running,
   input  logic             finish,
   input  logic [WIDTH-1:0] cut_out,
   output logic [WIDTH-1:0] signature,
   output logic             done,
   output logic             pass,
   output logic             fail,
   output logic [1:0]       err_code
);

   // Counter is wide enough to tell NCLOCK apart from "one too many"
   localparam int             CW      = $clog2(NCLOCK + 2);
   localparam logic [CW-1:0]  CNT_MAX = '1;
   localparam logic [CW-1:0]  CNT_EXP = CW'(NCLOCK);

   state_t           r_state;
   state_t           w_next;
   logic [CW-1:0]    r_cnt;
   logic             r_proto_err;
   logic             r_done;
   logic             r_pass;
   logic             r_fail;
   logic [1:0]       r_err;
   logic [WIDTH-1:0] w_sig;
   logic             w_step;
   logic             w_verdict_ld;
   logic             w_proto_set;
   logic [1:0]       w_err;

   bist_misr #(
      .WIDTH (WIDTH),
      .POLY  (POLY)
   ) u_misr (
      .clk     (clk),
      .reset_n (reset_n),
      .clear   (init),
      .en      (w_step),
      .din     (cut_out),
      .q       (w_sig)
   );

   // State register
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         r_state <= ST_IDLE;
      end else begin
         r_state <= w_next;
      end
   end

   // Next-state logic: init restarts from any state
   always_comb begin
      w_next = r_state;
      if (init) begin
         w_next = ST_COMPACT;
      end else begin
         case (r_state)
            ST_IDLE:    if (running || finish) w_next = ST_CHECK;
            ST_COMPACT: if (finish)            w_next = ST_CHECK;
            ST_CHECK:   w_next = ST_DONE;
            ST_DONE:    w_next = ST_DONE;
            default:    w_next = ST_IDLE;
         endcase
      end
   end

   // Control outputs and verdict priority: protocol, then count, then signature
   always_comb begin
      w_step       = (r_state == ST_COMPACT) && running && !init;
      w_verdict_ld = (r_state == ST_CHECK) && !init;
      w_proto_set  = (init && finish) ||
                     (!init && (r_state == ST_IDLE) && (running || finish));
      w_err        = ERR_NONE;
      if (r_proto_err) begin
         w_err = ERR_PROTO;
      end else if (r_cnt != CNT_EXP) begin
         w_err = ERR_CNT;
      end else if (w_sig != GOLDEN) begin
         w_err = ERR_SIG;
      end
   end

   // Compaction-cycle counter, saturating so overruns never wrap back to NCLOCK
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         r_cnt <= '0;
      end else if (init) begin
         r_cnt <= '0;
      end else if (w_step && (r_cnt != CNT_MAX)) begin
         r_cnt <= r_cnt + 1'b1;
      end
   end

   // Sticky protocol-error flag; init clears it unless finish arrives alongside
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         r_proto_err <= 1'b0;
      end else if (init) begin
         r_proto_err <= finish;
      end else if (w_proto_set) begin
         r_proto_err <= 1'b1;
      end
   end

   // Verdict registers, loaded on the CHECK->DONE edge and held until init/reset
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         r_done <= 1'b0;
         r_pass <= 1'b0;
         r_fail <= 1'b0;
         r_err  <= ERR_NONE;
      end else if (init) begin
         r_done <= 1'b0;
         r_pass <= 1'b0;
         r_fail <= 1'b0;
         r_err  <= ERR_NONE;
      end else if (w_verdict_ld) begin
         r_done <= 1'b1;
         r_pass <= (w_err == ERR_NONE);
         r_fail <= (w_err != ERR_NONE);
         r_err  <= w_err;
      end
   end

   assign signature = w_sig;
   assign done      = r_done;
   assign pass      = r_pass;
   assign fail      = r_fail;
   assign err_code  = r_err;

endmodule
